prog_loader_ram: RTL and testbench

- Writable program memory that replaces the fixed instruction ROM in front of simple_cpu.
- The CPU side is an unchanged synchronous read port (rom_addr in, rom_data out, 1-cycle latency).
- The load side accepts a framed byte stream over a valid/ready handshake and assembles 32-bit words into the RAM.
- The block holds the CPU in reset until a complete frame with a valid checksum has been written.

---
 rtl/prog_loader_ram_if.sv | 10 +
 rtl/prog_loader_ram.sv | 183 ++++++++++++++++++
 tb/tb_prog_loader_ram.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_ram_if.sv
// Byte-stream load channel for prog_loader_ram: the master drives data/valid,
// the loader (slave) answers with ready.
interface prog_loader_ram_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/prog_loader_ram.sv
// Writable program RAM for simple_cpu, loaded from framed bytes (HEADER, LEN, data, CSUM).
// Optional inter-byte timeout enabled by defining PROG_LOADER_TIMEOUT_EN.
module prog_loader_ram #(
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [31:0]           rom_data,
    prog_loader_ram_if.slave      ld,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   word_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [8:0]            words_left_q, words_left_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           buf_q, buf_d;
    logic [7:0]            csum_q, csum_d;
    logic [31:0]           rom_data_q;
    logic [31:0]           mem_q [0:DEPTH-1];

    logic                  accept;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [31:0]           ram_wdata;

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

    assign accept      = ld.in_valid && in_ready_q;
    assign ld.in_ready = in_ready_q;
    assign rom_data    = rom_data_q;
    assign cpu_reset   = cpu_reset_q;
    assign load_done   = load_done_q;
    assign load_error  = load_error_q;
    assign word_count  = word_count_q;

    always_comb begin
        state_d      = state_q;
        in_ready_d   = 1'b1;
        cpu_reset_d  = cpu_reset_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        word_count_d = word_count_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        buf_d        = buf_q;
        csum_d       = csum_q;
        ram_we       = 1'b0;
        ram_waddr    = addr_q;
        ram_wdata    = {ld.in_data, buf_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept && ld.in_data == HEADER) begin
                    state_d      = S_LEN;
                    cpu_reset_d  = 1'b1;
                    load_done_d  = 1'b0;
                    load_error_d = 1'b0;
                    word_count_d = '0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    words_left_d = (ld.in_data == 8'd0) ? 9'd256 : {1'b0, ld.in_data};
                    addr_d       = '0;
                    csum_d       = '0;
                    byte_idx_d   = '0;
                    state_d      = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d     = csum_q + ld.in_data;
                    byte_idx_d = byte_idx_q + 1'b1;
                    // Bytes arrive LSB first, so shift in from the top.
                    buf_d      = {ld.in_data, buf_q[23:8]};
                    if (byte_idx_q == 2'd3) begin
                        ram_we       = 1'b1;
                        addr_d       = addr_q + 1'b1;
                        word_count_d = word_count_q + 1'b1;
                        words_left_d = words_left_q - 1'b1;
                        if (words_left_q == 9'd1) state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (ld.in_data == csum_q) begin
                        load_done_d = 1'b1;
                        cpu_reset_d = 1'b0;
                        state_d     = S_DONE;
                    end else begin
                        load_error_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef PROG_LOADER_TIMEOUT_EN
        to_cnt_d = '0;
        if (state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM) begin
            if (accept) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                // Timeout overrides whatever the stalled state would have done.
                load_error_d = 1'b1;
                cpu_reset_d  = 1'b1;
                byte_idx_d   = '0;
                state_d      = S_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            word_count_q <= '0;
            addr_q       <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            buf_q        <= '0;
            csum_q       <= '0;
            rom_data_q   <= '0;
`ifdef PROG_LOADER_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            word_count_q <= word_count_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            buf_q        <= buf_d;
            csum_q       <= csum_d;
            rom_data_q   <= mem_q[rom_addr];
`ifdef PROG_LOADER_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    // Storage has no reset; read-first falls out of the non-blocking write.
    always_ff @(posedge clk) begin
        if (ram_we) mem_q[ram_waddr] <= ram_wdata;
    end
endmodule

// File: tb/tb_prog_loader_ram.sv
// Directed self-checking bench for prog_loader_ram (main instance plus a
// 4-word instance for address wrap).
module tb_prog_loader_ram;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        cpu_reset, load_done, load_error;
    logic [8:0]  word_count;

    logic [1:0]  rom_addr_w;
    logic [31:0] rom_data_w;
    logic        cpu_reset_w, load_done_w, load_error_w;
    logic [2:0]  word_count_w;

    int checks = 0;
    int errors = 0;
    logic [31:0] fw [0:255];

    prog_loader_ram_if ld ();
    prog_loader_ram_if lw ();

    prog_loader_ram #(.ADDR_WIDTH(8), .HEADER(8'hA5), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data), .ld(ld.slave),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error),
        .word_count(word_count)
    );

    prog_loader_ram #(.ADDR_WIDTH(2), .HEADER(8'hA5), .TIMEOUT_CYCLES(100)) dut_w (
        .clk(clk), .reset(reset), .rom_addr(rom_addr_w), .rom_data(rom_data_w), .ld(lw.slave),
        .cpu_reset(cpu_reset_w), .load_done(load_done_w), .load_error(load_error_w),
        .word_count(word_count_w)
    );

    // Called at #1 after a posedge; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            while ($urandom_range(0, 99) < 30) begin
                @(posedge clk); #1;
            end
        end
        ld.in_data = b;
        ld.in_valid = 1'b1;
        checks++;
        if (ld.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready: got %b expected 1", ld.in_ready);
        end
        @(posedge clk); #1;
        ld.in_valid = 1'b0;
    endtask

    task automatic send_byte_w(input logic [7:0] b);
        lw.in_data = b;
        lw.in_valid = 1'b1;
        @(posedge clk); #1;
        lw.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] len, input bit use_csum,
                              input logic [7:0] forced_csum, input bit gaps);
        int unsigned n;
        logic [7:0] cs;
        logic [31:0] w;
        n = (len == 8'd0) ? 256 : int'(len);
        cs = 8'h00;
        send_byte(8'hA5, gaps);
        send_byte(len, gaps);
        for (int unsigned i = 0; i < n; i++) begin
            w = fw[i];
            for (int unsigned j = 0; j < 4; j++) begin
                cs = cs + w[8*j +: 8];
                send_byte(w[8*j +: 8], gaps);
            end
        end
        send_byte(use_csum ? cs : forced_csum, gaps);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rom_addr = '0;
        rom_addr_w = '0;
        ld.in_valid = 1'b0;
        ld.in_data = '0;
        lw.in_valid = 1'b0;
        lw.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ld.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", ld.in_ready); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset: got %b expected 1", cpu_reset); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rst_load_done: got %b expected 0", load_done); end
        checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL rst_load_error: got %b expected 0", load_error); end
        checks++; if (word_count !== 9'd0) begin errors++; $display("FAIL rst_word_count: got %0d expected 0", word_count); end
        checks++; if (rom_data !== 32'h0) begin errors++; $display("FAIL rst_rom_data: got %h expected 0", rom_data); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (ld.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %b expected 1", ld.in_ready); end
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL idle_cpu_reset: got %b expected 1", cpu_reset); end
        checks++; if (load_done !== 1'b0 || load_error !== 1'b0) begin errors++; $display("FAIL idle_flags: got %b%b expected 00", load_done, load_error); end
        checks++; if (word_count !== 9'd0) begin errors++; $display("FAIL idle_word_count: got %0d expected 0", word_count); end
    endtask

    task automatic test_frame_good;
        fw[0] = 32'h12345678;
        fw[1] = 32'hDEADBEEF;
        send_frame(8'd2, 1'b1, 8'h00, 1'b0);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL good_load_done: got %b expected 1", load_done); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL good_cpu_reset: got %b expected 0", cpu_reset); end
        checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL good_load_error: got %b expected 0", load_error); end
        checks++; if (word_count !== 9'd2) begin errors++; $display("FAIL good_word_count: got %0d expected 2", word_count); end
        rom_addr = 8'd1;
        @(posedge clk); #1;
        checks++; if (rom_data !== 32'hDEADBEEF) begin errors++; $display("FAIL good_rd1: got %h expected deadbeef", rom_data); end
        rom_addr = 8'd0;
        @(posedge clk); #1;
        checks++; if (rom_data !== 32'h12345678) begin errors++; $display("FAIL good_rd0: got %h expected 12345678", rom_data); end
    endtask

    task automatic test_bad_csum;
        send_frame(8'd2, 1'b0, 8'h00, 1'b0);
        checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL bad_load_error: got %b expected 1", load_error); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL bad_load_done: got %b expected 0", load_done); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL bad_cpu_reset: got %b expected 1", cpu_reset); end
        send_byte(8'h02, 1'b0);
        checks++; if (load_error !== 1'b1 || cpu_reset !== 1'b1) begin errors++; $display("FAIL bad_idle_discard: got %b%b expected 11", load_error, cpu_reset); end
        send_frame(8'd2, 1'b1, 8'h00, 1'b0);
        checks++; if (load_done !== 1'b1 || load_error !== 1'b0) begin errors++; $display("FAIL bad_then_good: got done=%b err=%b expected done=1 err=0", load_done, load_error); end
    endtask

    task automatic test_restart;
        send_byte(8'h33, 1'b0);
        checks++; if (cpu_reset !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL done_discard: got cr=%b done=%b expected cr=0 done=1", cpu_reset, load_done); end
        send_byte(8'hA5, 1'b0);
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL restart_cpu_reset: got %b expected 1", cpu_reset); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL restart_load_done: got %b expected 0", load_done); end
        checks++; if (word_count !== 9'd0) begin errors++; $display("FAIL restart_word_count: got %0d expected 0", word_count); end
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        checks++; if (load_done !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL restart_done: got done=%b cr=%b expected done=1 cr=0", load_done, cpu_reset); end
        rom_addr = 8'd0;
        @(posedge clk); #1;
        checks++; if (rom_data !== 32'h00000001) begin errors++; $display("FAIL restart_rd0: got %h expected 00000001", rom_data); end
    endtask

    task automatic test_long_frame;
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            fw[i] = {b, ~b, b ^ 8'h5A, b + 8'h3C};
        end
        send_frame(8'd0, 1'b1, 8'h00, 1'b1);
        checks++; if (word_count !== 9'd256) begin errors++; $display("FAIL long_word_count: got %0d expected 256", word_count); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL long_load_done: got %b expected 1", load_done); end
        for (int i = 0; i < 256; i++) begin
            rom_addr = 8'(i);
            @(posedge clk); #1;
            checks++;
            if (rom_data !== fw[i]) begin errors++; $display("FAIL long_rd[%0d]: got %h expected %h", i, rom_data, fw[i]); end
        end
    endtask

    task automatic test_collision;
        logic [31:0] old_w;
        old_w = fw[0];
        rom_addr = 8'd0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h0D, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'hFE, 1'b0);
        send_byte(8'hCA, 1'b0);
        checks++; if (rom_data !== old_w) begin errors++; $display("FAIL collision_old: got %h expected %h", rom_data, old_w); end
        @(posedge clk); #1;
        checks++; if (rom_data !== 32'hCAFEF00D) begin errors++; $display("FAIL collision_new: got %h expected cafef00d", rom_data); end
        send_byte(8'hC5, 1'b0);
        checks++; if (load_done !== 1'b1 || word_count !== 9'd1) begin errors++; $display("FAIL collision_done: got done=%b wc=%0d expected done=1 wc=1", load_done, word_count); end
    endtask

    task automatic test_wrap;
        logic [31:0] ww [0:4];
        logic [7:0] cs;
        logic [31:0] w;
        ww[0] = 32'h00000010; ww[1] = 32'h11111111; ww[2] = 32'h22222222;
        ww[3] = 32'h33333333; ww[4] = 32'h44444444;
        cs = 8'h00;
        send_byte_w(8'hA5);
        send_byte_w(8'd5);
        for (int i = 0; i < 5; i++) begin
            w = ww[i];
            for (int j = 0; j < 4; j++) begin
                cs = cs + w[8*j +: 8];
                send_byte_w(w[8*j +: 8]);
            end
        end
        send_byte_w(cs);
        checks++; if (word_count_w !== 3'd5) begin errors++; $display("FAIL wrap_word_count: got %0d expected 5", word_count_w); end
        checks++; if (load_done_w !== 1'b1) begin errors++; $display("FAIL wrap_load_done: got %b expected 1", load_done_w); end
        rom_addr_w = 2'd0;
        @(posedge clk); #1;
        checks++; if (rom_data_w !== 32'h44444444) begin errors++; $display("FAIL wrap_rd0: got %h expected 44444444", rom_data_w); end
        rom_addr_w = 2'd1;
        @(posedge clk); #1;
        checks++; if (rom_data_w !== 32'h11111111) begin errors++; $display("FAIL wrap_rd1: got %h expected 11111111", rom_data_w); end
    endtask

    task automatic test_async_reset;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        #2 reset = 1'b1;
        #1;
        checks++; if (ld.in_ready !== 1'b0 || cpu_reset !== 1'b1) begin errors++; $display("FAIL areset_ready_cr: got rdy=%b cr=%b expected rdy=0 cr=1", ld.in_ready, cpu_reset); end
        checks++; if (load_done !== 1'b0 || load_error !== 1'b0 || word_count !== 9'd0) begin errors++; $display("FAIL areset_status: got done=%b err=%b wc=%0d expected 0 0 0", load_done, load_error, word_count); end
        checks++; if (rom_data !== 32'h0) begin errors++; $display("FAIL areset_rom_data: got %h expected 0", rom_data); end
        #2 reset = 1'b0;
        rom_addr = 8'd0;
        @(posedge clk); #1;
        checks++; if (ld.in_ready !== 1'b1) begin errors++; $display("FAIL areset_release: got %b expected 1", ld.in_ready); end
        checks++; if (rom_data !== 32'hCAFEF00D) begin errors++; $display("FAIL areset_ram_kept: got %h expected cafef00d", rom_data); end
    endtask

    task automatic test_timeout;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h11, 1'b0);
        repeat (100) @(posedge clk);
        #1;
`ifdef PROG_LOADER_TIMEOUT_EN
        checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b expected 1", load_error); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL timeout_cpu_reset: got %b expected 1", cpu_reset); end
        fw[0] = 32'h44332211;
        send_frame(8'd1, 1'b1, 8'h00, 1'b0);
`else
        checks++; if (load_error !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL stall_pending: got err=%b done=%b expected 0 0", load_error, load_done); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL stall_cpu_reset: got %b expected 1", cpu_reset); end
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'hAA, 1'b0);
`endif
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL after_stall_done: got %b expected 1", load_done); end
        rom_addr = 8'd0;
        @(posedge clk); #1;
        checks++; if (rom_data !== 32'h44332211) begin errors++; $display("FAIL after_stall_rd0: got %h expected 44332211", rom_data); end
    endtask

    initial begin
        test_reset;
        test_frame_good;
        test_bad_csum;
        test_restart;
        test_long_frame;
        test_collision;
        test_wrap;
        test_async_reset;
        test_timeout;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
